// File: rtl/sync_array.sv
// sync_array: multi-channel synchroniser in the destination clock domain.
// Each channel carries an independent word through a Stages-deep flop chain.
// An optional stability filter rejects short-lived values, and the result
// can optionally be Gray-decoded. dout is registered, and a one-cycle
// 'changed' strobe marks each update of each channel.

module sync_array #(
    parameter int          Channels     = 2,
    parameter int          ChannelWidth = 4,
    parameter int          Stages       = 2,
    parameter logic [31:0] InitValue    = 32'h0000_0000,
    parameter int          StableCycles = 0,
    parameter int          GrayDecode   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Channels*ChannelWidth-1:0] din,
    output logic [Channels*ChannelWidth-1:0] dout,
    output logic [Channels-1:0]              changed
);

    // Parameter range checks, resolved at elaboration time.
    if ((Channels < 1) || (Channels > 16)) begin : g_bad_channels
        $error("sync_array: Channels must be in 1..16");
    end
    if ((ChannelWidth < 1) || (ChannelWidth > 32)) begin : g_bad_width
        $error("sync_array: ChannelWidth must be in 1..32");
    end
    if ((Stages < 1) || (Stages > 8)) begin : g_bad_stages
        $error("sync_array: Stages must be in 1..8");
    end
    if ((StableCycles < 0) || (StableCycles > 255)) begin : g_bad_stable
        $error("sync_array: StableCycles must be in 0..255");
    end
    if ((GrayDecode != 0) && (GrayDecode != 1)) begin : g_bad_gray
        $error("sync_array: GrayDecode must be 0 or 1");
    end

    // Gray-to-binary: the MSB passes through, every lower bit is the XOR
    // of the binary bit above it and its own Gray bit.
    function automatic logic [ChannelWidth-1:0] gray2bin(input logic [ChannelWidth-1:0] g);
        logic [ChannelWidth-1:0] b;
        b = g;
        for (int k = ChannelWidth - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Output encoding applied to every value loaded into dout.
    function automatic logic [ChannelWidth-1:0] decode(input logic [ChannelWidth-1:0] x);
        logic [ChannelWidth-1:0] y;
        if (GrayDecode != 0) begin
            y = gray2bin(x);
        end else begin
            y = x;
        end
        return y;
    endfunction

    localparam int                      CntW     = (StableCycles < 1) ? 1 : $clog2(StableCycles + 1);
    localparam logic [ChannelWidth-1:0] InitRaw  = InitValue[ChannelWidth-1:0];
    localparam logic [ChannelWidth-1:0] InitOut  = decode(InitRaw);
    localparam logic [CntW-1:0]         CntMax   = CntW'(StableCycles);
    localparam logic [CntW-1:0]         CntOne   = CntW'(32'd1);
    localparam logic [CntW-1:0]         CntZero  = CntW'(32'd0);
    localparam bit                      FilterOn = (StableCycles != 0);

    for (genvar ch = 0; ch < Channels; ch++) begin : g_chan
        logic [ChannelWidth-1:0] sync_r [Stages];
        logic [ChannelWidth-1:0] tail_s;
        logic [ChannelWidth-1:0] held_r;
        logic [ChannelWidth-1:0] held_s;
        logic [ChannelWidth-1:0] cand_r;
        logic [ChannelWidth-1:0] cand_s;
        logic [ChannelWidth-1:0] dout_r;
        logic [ChannelWidth-1:0] dout_s;
        logic [CntW-1:0]         cnt_r;
        logic [CntW-1:0]         cnt_s;
        logic                    chg_r;
        logic                    chg_s;

        // Synchroniser chain: plain shift, first stage samples the async input.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < Stages; k++) begin
                    sync_r[k] <= InitRaw;
                end
            end else begin
                sync_r[0] <= din[ch*ChannelWidth +: ChannelWidth];
                for (int k = 1; k < Stages; k++) begin
                    sync_r[k] <= sync_r[k-1];
                end
            end
        end

        assign tail_s = sync_r[Stages-1];

        // Update decision: direct pass in bypass mode, otherwise a candidate
        // must be seen unchanged for StableCycles+1 edges before it is accepted.
        always_comb begin
            held_s = held_r;
            cand_s = cand_r;
            cnt_s  = cnt_r;
            dout_s = dout_r;
            chg_s  = 1'b0;
            if (!FilterOn) begin
                if (tail_s != held_r) begin
                    held_s = tail_s;
                    dout_s = decode(tail_s);
                    chg_s  = 1'b1;
                end else begin
                    chg_s  = 1'b0;
                end
            end else if (tail_s == held_r) begin
                // Back to the held value: any pending candidate is dropped.
                cnt_s  = CntZero;
                cand_s = tail_s;
                chg_s  = 1'b0;
            end else if (tail_s != cand_r) begin
                // A different value restarts qualification from zero.
                cand_s = tail_s;
                cnt_s  = CntZero;
                chg_s  = 1'b0;
            end else if (cnt_r != CntMax) begin
                cnt_s  = cnt_r + CntOne;
                chg_s  = 1'b0;
            end else begin
                held_s = tail_s;
                dout_s = decode(tail_s);
                cnt_s  = CntZero;
                chg_s  = 1'b1;
            end
        end

        // Held value, candidate, counter and output registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                held_r <= InitRaw;
                cand_r <= InitRaw;
                cnt_r  <= CntZero;
                dout_r <= InitOut;
                chg_r  <= 1'b0;
            end else begin
                held_r <= held_s;
                cand_r <= cand_s;
                cnt_r  <= cnt_s;
                dout_r <= dout_s;
                chg_r  <= chg_s;
            end
        end

        assign dout[ch*ChannelWidth +: ChannelWidth] = dout_r;
        assign changed[ch]                           = chg_r;
    end

endmodule

// File: tb/tb_sync_array.sv
// tb_sync_array: table-driven bench for sync_array. Four instances cover
// InitValue=5, defaults, StableCycles=3 and GrayDecode=1. Each vector drives
// one instance for one clock; its expected outputs are queued when driven
// and popped and compared #1 after the following rising edge.

module tb_sync_array;

    logic       clk = 1'b0;
    logic       rst_v  [4];
    logic [7:0] din_v  [4];
    logic [7:0] dout_v [4];
    logic [1:0] chg_v  [4];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sync_array #(.Channels(2), .ChannelWidth(4), .Stages(2), .InitValue(32'h5),
                 .StableCycles(0), .GrayDecode(0)) u_init (
        .clk(clk), .rst(rst_v[0]), .din(din_v[0]), .dout(dout_v[0]), .changed(chg_v[0]));

    sync_array #(.Channels(2), .ChannelWidth(4), .Stages(2), .InitValue(32'h0),
                 .StableCycles(0), .GrayDecode(0)) u_dflt (
        .clk(clk), .rst(rst_v[1]), .din(din_v[1]), .dout(dout_v[1]), .changed(chg_v[1]));

    sync_array #(.Channels(2), .ChannelWidth(4), .Stages(2), .InitValue(32'h0),
                 .StableCycles(3), .GrayDecode(0)) u_filt (
        .clk(clk), .rst(rst_v[2]), .din(din_v[2]), .dout(dout_v[2]), .changed(chg_v[2]));

    sync_array #(.Channels(2), .ChannelWidth(4), .Stages(2), .InitValue(32'h0),
                 .StableCycles(0), .GrayDecode(1)) u_gray (
        .clk(clk), .rst(rst_v[3]), .din(din_v[3]), .dout(dout_v[3]), .changed(chg_v[3]));

    typedef struct {
        int         sel;
        logic       rst;
        logic [7:0] din;
        logic [7:0] dout;
        logic [1:0] chg;
        string      tag;
    } vec_t;

    typedef struct {
        int         sel;
        logic [7:0] dout;
        logic [1:0] chg;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    function automatic vec_t mk(input int sel, input logic r, input logic [7:0] d,
                                input logic [7:0] q, input logic [1:0] c, input string tag);
        vec_t v;
        v.sel = sel; v.rst = r; v.din = d; v.dout = q; v.chg = c; v.tag = tag;
        return v;
    endfunction

    task automatic add(input int n, input int sel, input logic r, input logic [7:0] d,
                       input logic [7:0] q, input logic [1:0] c, input string tag);
        for (int k = 0; k < n; k++) begin
            vecs.push_back(mk(sel, r, d, q, c, tag));
        end
    endtask

    task automatic check();
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard: got empty queue, required one pending entry");
        end else begin
            e = sbq.pop_front();
            tests++;
            if (dout_v[e.sel] !== e.dout) begin
                failed++;
                $display("FAIL %s dout[dut%0d]: got %h required %h", e.tag, e.sel, dout_v[e.sel], e.dout);
            end
            tests++;
            if (chg_v[e.sel] !== e.chg) begin
                failed++;
                $display("FAIL %s changed[dut%0d]: got %b required %b", e.tag, e.sel, chg_v[e.sel], e.chg);
            end
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_v[v.sel] = v.rst;
        din_v[v.sel] = v.din;
        e.sel = v.sel; e.dout = v.dout; e.chg = v.chg; e.tag = v.tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1;
            din_v[k] = 8'h00;
        end
        din_v[0] = 8'hFF;

        // InitValue=5: reset holds 55, FF arrives at edge 3 after release.
        add(3, 0, 1'b1, 8'hFF, 8'h55, 2'b00, "init_rst");
        add(2, 0, 1'b0, 8'hFF, 8'h55, 2'b00, "init_rel");
        add(1, 0, 1'b0, 8'hFF, 8'hFF, 2'b11, "init_upd");
        add(1, 0, 1'b0, 8'hFF, 8'hFF, 2'b00, "init_post");

        // Defaults: latency S+1, channel independence, simultaneous change.
        add(2, 1, 1'b1, 8'h00, 8'h00, 2'b00, "dflt_rst");
        add(2, 1, 1'b0, 8'h0A, 8'h00, 2'b00, "lat_wait");
        add(1, 1, 1'b0, 8'h0A, 8'h0A, 2'b01, "lat_upd");
        add(2, 1, 1'b0, 8'h0A, 8'h0A, 2'b00, "lat_hold");
        add(2, 1, 1'b0, 8'h0F, 8'h0A, 2'b00, "prep_wait");
        add(1, 1, 1'b0, 8'h0F, 8'h0F, 2'b01, "prep_upd");
        add(1, 1, 1'b0, 8'h0F, 8'h0F, 2'b00, "prep_hold");
        add(2, 1, 1'b0, 8'hF0, 8'h0F, 2'b00, "simul_wait");
        add(1, 1, 1'b0, 8'hF0, 8'hF0, 2'b11, "simul_upd");
        add(1, 1, 1'b0, 8'hF0, 8'hF0, 2'b00, "simul_hold");

        // StableCycles=3: held 4 rejected, held 5 passes at edge 7.
        add(2, 2, 1'b1, 8'h00, 8'h00, 2'b00, "filt_rst");
        add(4, 2, 1'b0, 8'h03, 8'h00, 2'b00, "short_in");
        add(8, 2, 1'b0, 8'h00, 8'h00, 2'b00, "short_out");
        add(5, 2, 1'b0, 8'h03, 8'h00, 2'b00, "pass_in");
        add(1, 2, 1'b0, 8'h00, 8'h00, 2'b00, "pass_wait");
        add(1, 2, 1'b0, 8'h00, 8'h03, 2'b01, "pass_upd");
        add(4, 2, 1'b0, 8'h00, 8'h03, 2'b00, "pass_hold");
        add(1, 2, 1'b0, 8'h00, 8'h00, 2'b01, "back_upd");
        add(1, 2, 1'b0, 8'h00, 8'h00, 2'b00, "back_hold");
        // 3 for three cycles then 6: count restarts, only 6 lands at edge 10.
        add(3, 2, 1'b0, 8'h03, 8'h00, 2'b00, "restart_3");
        add(6, 2, 1'b0, 8'h06, 8'h00, 2'b00, "restart_6");
        add(1, 2, 1'b0, 8'h06, 8'h06, 2'b01, "restart_upd");
        add(1, 2, 1'b0, 8'h06, 8'h06, 2'b00, "restart_hold");

        // GrayDecode=1: Gray code 0..15, one step every 4 cycles.
        add(2, 3, 1'b1, 8'h00, 8'h00, 2'b00, "gray_rst");
        for (int i = 0; i < 16; i++) begin
            logic [7:0] g;
            logic [7:0] b;
            logic [7:0] p;
            b = 8'(i);
            g = b ^ (b >> 1);
            p = (i == 0) ? 8'h00 : 8'(i - 1);
            add(2, 3, 1'b0, g, p, 2'b00, $sformatf("gray%0d_wait", i));
            add(1, 3, 1'b0, g, b, (i == 0) ? 2'b00 : 2'b01, $sformatf("gray%0d_upd", i));
            add(1, 3, 1'b0, g, b, 2'b00, $sformatf("gray%0d_hold", i));
        end
        add(2, 3, 1'b0, 8'h06, 8'h0F, 2'b00, "g0110_wait");
        add(1, 3, 1'b0, 8'h06, 8'h04, 2'b01, "g0110_upd");
        add(1, 3, 1'b0, 8'h06, 8'h04, 2'b00, "g0110_hold");

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // Reset while the filter counter sits at 2: nothing passes, and the
        // candidate needs a full S+2+N edges again after release.
        for (int k = 0; k < 5; k++) step(mk(2, 1'b0, 8'h03, 8'h06, 2'b00, "midrst_pre"));
        step(mk(2, 1'b1, 8'h03, 8'h00, 2'b00, "midrst_rst"));
        for (int k = 0; k < 6; k++) step(mk(2, 1'b0, 8'h03, 8'h00, 2'b00, "midrst_requal"));
        step(mk(2, 1'b0, 8'h03, 8'h03, 2'b01, "midrst_upd"));
        step(mk(2, 1'b0, 8'h03, 8'h03, 2'b00, "midrst_hold"));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sync_array.md
Name: sync_array

Overview:
- Multi-channel synchroniser in the destination clock domain. Brings Channels independent words from an asynchronous source through a Stages-deep flop chain.
- Optional per-channel stability (glitch/skew) filter before the output register.
- Optional Gray-to-binary decode of the synchronised value.
- Per-channel one-cycle change strobe.
- Successor to the single-word shift synchroniser, for CDC of status words, slow counters and config buses.

Parameters:
- Channels, 2: number of independent channels (1..16).
- ChannelWidth, 4: bits per channel (1..32).
- Stages, 2: synchroniser flops per channel (1..8). Out of range is an elaboration error.
- InitValue, 0: per-channel reset value (ChannelWidth LSBs used), applied to every channel.
- StableCycles, 0: filter depth (0..255). 0 = filter bypassed.
- GrayDecode, 0: 1 = din is Gray code and dout is binary. 0 = dout is raw.

Ports:
- clk  in  1  destination-domain clock.
- rst  in  1  reset, synchronous, active-high.
- din  in  Channels*ChannelWidth  asynchronous source data. Channel i is bits [i*ChannelWidth +: ChannelWidth].
- dout  out  Channels*ChannelWidth  synchronised (filtered/decoded) data, registered.
- changed  out  Channels  one-cycle pulse: dout channel i updated at the preceding edge.

Behaviour:
- Per channel: chain r1..rS (S=Stages), candidate c, held value h (raw), counter cnt of width max(1, clog2(StableCycles+1)), dout register, changed flop.
- Reset (rst=1 at an edge):
  - r*, c and h <= InitValue; cnt <= 0; changed <= 0.
  - dout <= InitValue, or gray2bin(InitValue) if GrayDecode.
  - Reset mid-count discards any pending candidate.
  - No changed pulse on the reset edge or on the first edge after release.
- Chain: r1 <= din channel; rk <= r(k-1). Pure shift, no enable.
- Filter bypass (StableCycles=0):
  - If rS != h: h <= rS; dout <= dec(rS); changed <= 1. Otherwise changed <= 0.
  - Latency: din stable before edge 1 -> dout updates at edge S+1, changed high during the following cycle.
  - Every distinct synchronised value propagates.
- Filter active (StableCycles=N>=1), evaluated each edge in priority order:
  - rS == h: cnt <= 0; c <= rS; changed <= 0.
  - rS != h and rS != c: c <= rS; cnt <= 0 (new candidate restarts the count).
  - rS == c and cnt < N: cnt <= cnt+1.
  - rS == c and cnt == N: h <= rS; dout <= dec(rS); cnt <= 0; changed <= 1.
  - Latency: edge S+2+N. A din value held L cycles is passed iff L >= N+2; L <= N+1 is rejected silently.
- Output encoding: dec(x) = gray2bin(x) when GrayDecode=1 (b[W-1]=g[W-1], b[k]=b[k+1]^g[k]), else x.
- changed: exactly one cycle per update. Channels are fully independent; simultaneous changes on several channels pulse their bits in the same cycle.
- No combinational path from din to any output.

Test Plan:
- Reset, InitValue=4'h5:
  - Stimulus: din=8'hFF, rst high 3 cycles, then released.
  - Required: dout=8'h55 throughout reset and until the chain delivers FF. changed=0 during reset and on the first post-reset cycle. dout=8'hFF at edge 3 after release, changed=2'b11 for one cycle.
- Latency and independence, defaults:
  - Stimulus: ch0 din 0->4'hA just before edge 1.
  - Required: dout[3:0]=4'hA after edge 3, changed=2'b01 for exactly one cycle, dout[7:4] unchanged.
- Filter, StableCycles=3:
  - Stimulus: ch0 = 4'h3 held 4 cycles, then back to 0.
  - Required: dout stays 0, changed never asserts.
  - Stimulus: 4'h3 held 5 cycles.
  - Required: dout[3:0]=3 at edge S+5=7, one changed pulse.
  - Stimulus: 4'h3 for 3 cycles then 4'h6 held.
  - Required: count restarts, only 6 reaches dout (edge after 6 stable for 5 synchronised cycles).
- Gray decode, GrayDecode=1:
  - Stimulus: ch0 Gray sequence for 0..15, one step every 4 cycles.
  - Required: dout[3:0] = 0,1,...,15 in order, each step after edge S+1 of its change.
  - Stimulus: Gray 4'b0110.
  - Required: dout=4'h4.
- Simultaneous and wrap:
  - Stimulus: both channels change on the same edge (ch0 F->0, ch1 0->F).
  - Required: both update on the same edge, changed=2'b11 for one cycle.
- Reset mid-filter, StableCycles=3:
  - Stimulus: assert rst when cnt=2.
  - Required: no update, dout=InitValue, cnt=0, changed=0. Candidate must be re-qualified from scratch after release.
